// File: rtl/mem_watch_pkg.sv
// Shared types and parameter limits for the memory watch unit.
// Holds the FSM state encoding, default parameter values and legal ranges.
package mem_watch_pkg;

   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned ADDR_W_DEF = 5;
   localparam int unsigned RD_LAT_DEF = 1;
   localparam int unsigned DWELL_DEF  = 1024;

   localparam int unsigned RD_LAT_MIN = 1;
   localparam int unsigned RD_LAT_MAX = 4;
   localparam int unsigned DWELL_MIN  = 1;

   typedef enum logic [1:0] {
      ST_ISSUE = 2'd0,
      ST_WAIT  = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

endpackage

// File: rtl/mem_watch_unit_if.sv
// Read bus between the watch unit (master) and the watched memory (slave).
interface mem_watch_unit_if
   import mem_watch_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
);

   logic              rd_en;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] rd_data;

   modport master (output rd_en, output addr, input rd_data);
   modport slave  (input rd_en, input addr, output rd_data);

endinterface

// File: rtl/rd_return_pipe.sv
// Tracks an outstanding read: RD_LAT-deep valid/address shift register whose
// last stage marks the cycle in which the returned word must be sampled.
module rd_return_pipe #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic              i_vld,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              o_cap,
   output logic [ADDR_W-1:0] o_addr
);

   logic [RD_LAT-1:0] r_vld;
   logic [ADDR_W-1:0] r_addr [RD_LAT];

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_vld <= '0;
         for (int i = 0; i < int'(RD_LAT); i++) r_addr[i] <= '0;
      end else begin
         r_vld[0]  <= i_vld;
         r_addr[0] <= i_addr;
         for (int i = 1; i < int'(RD_LAT); i++) begin
            r_vld[i]  <= r_vld[i-1];
            r_addr[i] <= r_addr[i-1];
         end
      end
   end

   assign o_cap  = r_vld[RD_LAT-1];
   assign o_addr = r_addr[RD_LAT-1];

endmodule

// File: rtl/mem_watch_unit.sv
// Memory watch unit: periodically reads one word (manual) or scans a range
// (auto) of a watched memory and holds the result on a registered display.
module mem_watch_unit
   import mem_watch_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned RD_LAT = RD_LAT_DEF,
   parameter int unsigned DWELL  = DWELL_DEF
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic              mode,
   input  logic [ADDR_W-1:0] sel_addr,
   input  logic [ADDR_W-1:0] scan_lo,
   input  logic [ADDR_W-1:0] scan_hi,
   input  logic              hold,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic [DATA_W-1:0] disp_data,
   output logic [ADDR_W-1:0] disp_addr,
   output logic              disp_valid
);

   localparam int unsigned DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int unsigned LAT_W   = $clog2(RD_LAT_MAX + 1);

   if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
      $error("mem_watch_unit: RD_LAT out of range");
   end
   if (DWELL < DWELL_MIN) begin : g_bad_dwell
      $error("mem_watch_unit: DWELL out of range");
   end

   state_t             r_state;
   logic [LAT_W-1:0]   r_lat;
   logic [DWELL_W-1:0] r_dwell;
   logic [ADDR_W-1:0]  r_addr;
   logic               r_auto;
   logic               r_issued;
   logic [DATA_W-1:0]  r_disp_data;
   logic [ADDR_W-1:0]  r_disp_addr;
   logic               r_disp_valid;

   logic              w_rd_en;
   logic [ADDR_W-1:0] w_next_addr;
   logic              w_sel_moved;
   logic              w_cap;
   logic [ADDR_W-1:0] w_cap_addr;

   // Auto scan steps only from an in-range auto address; anything else restarts at scan_lo.
   always_comb begin
      w_next_addr = scan_lo;
      if (!mode) begin
         w_next_addr = sel_addr;
      end else if (r_issued && r_auto && (scan_lo <= scan_hi) &&
                   (r_addr >= scan_lo) && (r_addr < scan_hi)) begin
         w_next_addr = r_addr + ADDR_W'(1);
      end
   end

   assign w_rd_en     = !rst && (r_state == ST_ISSUE) && !hold;
   assign w_sel_moved = !mode && !r_auto && (sel_addr != r_addr);

   assign mem_rd_en  = w_rd_en;
   assign mem_addr   = rst ? '0 : w_next_addr;
   assign disp_data  = r_disp_data;
   assign disp_addr  = r_disp_addr;
   assign disp_valid = r_disp_valid;

   rd_return_pipe #(
      .ADDR_W (ADDR_W),
      .RD_LAT (RD_LAT)
   ) u_rd_return_pipe (
      .clk_in (clk_in),
      .rst    (rst),
      .i_vld  (w_rd_en),
      .i_addr (mem_addr),
      .o_cap  (w_cap),
      .o_addr (w_cap_addr)
   );

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_state      <= ST_ISSUE;
         r_lat        <= '0;
         r_dwell      <= '0;
         r_addr       <= '0;
         r_auto       <= 1'b0;
         r_issued     <= 1'b0;
         r_disp_data  <= '0;
         r_disp_addr  <= '0;
         r_disp_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_ISSUE: begin
               if (!hold) begin
                  r_addr   <= w_next_addr;
                  r_auto   <= mode;
                  r_issued <= 1'b1;
                  r_lat    <= '0;
                  r_state  <= ST_WAIT;
               end
            end
            // An outstanding read always completes, regardless of hold or input changes.
            ST_WAIT: begin
               if (w_cap) begin
                  r_disp_data  <= mem_rd_data;
                  r_disp_addr  <= w_cap_addr;
                  r_disp_valid <= 1'b1;
               end
               if (r_lat == LAT_W'(RD_LAT - 1)) begin
                  r_lat   <= '0;
                  r_dwell <= '0;
                  r_state <= ST_SHOW;
               end else begin
                  r_lat <= r_lat + LAT_W'(1);
               end
            end
            ST_SHOW: begin
               if (!hold) begin
                  if (w_sel_moved || (r_dwell == DWELL_W'(DWELL - 1))) begin
                     r_dwell <= '0;
                     r_state <= ST_ISSUE;
                  end else begin
                     r_dwell <= r_dwell + DWELL_W'(1);
                  end
               end
            end
            default: r_state <= ST_ISSUE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_watch_unit.sv
// Randomized bench for mem_watch_unit against a cycle-timestamp reference model.
module tb_mem_watch_unit;

   localparam int unsigned DW  = 16;
   localparam int unsigned AW  = 5;
   localparam int unsigned RL  = 2;
   localparam int unsigned DWL = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          mode;
   logic [AW-1:0] sel, lo, hi;
   logic          hold;
   logic [DW-1:0] disp_data;
   logic [AW-1:0] disp_addr;
   logic          disp_valid;

   mem_watch_unit_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   mem_watch_unit #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(RL), .DWELL(DWL)) dut (
      .clk_in      (clk),
      .rst         (rst),
      .mode        (mode),
      .sel_addr    (sel),
      .scan_lo     (lo),
      .scan_hi     (hi),
      .hold        (hold),
      .mem_rd_en   (bus.rd_en),
      .mem_addr    (bus.addr),
      .mem_rd_data (bus.rd_data),
      .disp_data   (disp_data),
      .disp_addr   (disp_addr),
      .disp_valid  (disp_valid)
   );

   always #5 clk = ~clk;

   // watched memory and its read-latency pipe
   logic [DW-1:0] mem [32];
   logic          rq_vld  [RL];
   logic [AW-1:0] rq_addr [RL];
   bit            rand_wr, force_ff;

   // reference model: issue time, capture time and dwell progress as plain integers
   int            cyc, n_vec, n_err;
   bit            m_ready, m_showing, m_any, m_auto;
   int            m_cap, m_shown;
   logic [AW-1:0] m_tag, m_issued;
   logic [DW-1:0] e_data;
   logic [AW-1:0] e_addr;
   logic          e_valid;
   bit            obs_en;
   logic [AW-1:0] obs_addr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [AW-1:0] pick_addr(input bit f_mode, input logic [AW-1:0] f_sel,
                                                input logic [AW-1:0] f_lo, input logic [AW-1:0] f_hi);
      int lo_i, hi_i, prv;
      lo_i = int'(f_lo);
      hi_i = int'(f_hi);
      prv  = int'(m_issued);
      if (!f_mode) return f_sel;
      if (!m_any || !m_auto || lo_i > hi_i) return f_lo;
      if (prv < lo_i || prv > hi_i) return f_lo;
      return AW'(lo_i + (prv - lo_i + 1) % (hi_i - lo_i + 1));
   endfunction

   task automatic model_reset();
      m_ready = 1'b1; m_showing = 1'b0; m_any = 1'b0; m_auto = 1'b0;
      m_cap = -1; m_shown = 0; m_tag = '0; m_issued = '0;
      e_data = '0; e_addr = '0; e_valid = 1'b0;
   endtask

   task automatic step(input bit t_rst, input bit t_mode, input logic [AW-1:0] t_sel,
                       input logic [AW-1:0] t_lo, input logic [AW-1:0] t_hi, input bit t_hold);
      bit            e_en;
      logic [AW-1:0] e_ma;
      @(posedge clk);
      #1;
      rst = t_rst; mode = t_mode; sel = t_sel; lo = t_lo; hi = t_hi; hold = t_hold;
      if (rand_wr && $urandom_range(0, 3) == 0) mem[$urandom_range(0, 31)] = DW'($urandom);
      bus.rd_data = rq_vld[RL-1] ? mem[rq_addr[RL-1]] : (force_ff ? '1 : DW'($urandom));
      @(negedge clk);
      if (t_rst) model_reset();
      e_en = !t_rst && m_ready && !t_hold;
      e_ma = t_rst ? '0 : pick_addr(t_mode, t_sel, t_lo, t_hi);
      chk("rd_en", 32'(bus.rd_en), 32'(e_en));
      if (e_en || t_rst) chk("mem_addr", 32'(bus.addr), 32'(e_ma));
      chk("disp_valid", 32'(disp_valid), 32'(e_valid));
      chk("disp_data", 32'(disp_data), 32'(e_data));
      chk("disp_addr", 32'(disp_addr), 32'(e_addr));
      obs_en = bus.rd_en; obs_addr = bus.addr;
      for (int i = int'(RL) - 1; i > 0; i--) begin
         rq_vld[i] = rq_vld[i-1]; rq_addr[i] = rq_addr[i-1];
      end
      rq_vld[0] = bus.rd_en; rq_addr[0] = bus.addr;
      if (t_rst) begin
      end else if (e_en) begin
         m_tag = e_ma; m_issued = e_ma; m_cap = cyc + int'(RL);
         m_ready = 1'b0; m_any = 1'b1; m_auto = t_mode;
      end else if (m_cap == cyc) begin
         e_data = mem[m_tag]; e_addr = m_tag; e_valid = 1'b1;
         m_cap = -1; m_showing = 1'b1; m_shown = 0;
      end else if (m_showing && !t_hold) begin
         if (!t_mode && !m_auto && t_sel != m_issued) begin
            m_showing = 1'b0; m_ready = 1'b1;
         end else begin
            m_shown++;
            if (m_shown == int'(DWL)) begin m_showing = 1'b0; m_ready = 1'b1; end
         end
      end
      cyc++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int            q_cyc [$];
      logic [AW-1:0] q_adr [$];
      bit            found;
      int            n_str;
      bit            r_mode;
      logic [AW-1:0] r_sel, r_lo, r_hi;

      rst = 1'b1; mode = 1'b0; sel = '0; lo = '0; hi = '0; hold = 1'b0;
      bus.rd_data = '1;
      for (int i = 0; i < 32; i++) mem[i] = DW'($urandom);
      for (int i = 0; i < int'(RL); i++) begin rq_vld[i] = 1'b0; rq_addr[i] = '0; end
      n_vec = 0; n_err = 0; cyc = 0; rand_wr = 1'b0; force_ff = 1'b1;
      model_reset();

      // reset held with all-ones read data
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'd1, 5'd0, 5'd0, 1'b0);
      force_ff = 1'b0;

      // manual watch of address 1
      mem[1] = 16'hA5A5;
      step(1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 1'b0);
      chk("first_strobe", 32'(obs_en), 32'd1);
      chk("first_addr", 32'(obs_addr), 32'd1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 1'b0);
      chk("first_word", 32'(disp_data), 32'hA5A5);
      chk("first_waddr", 32'(disp_addr), 32'd1);

      mem[1] = 16'h1234;
      for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 1'b0);
      chk("refresh_word", 32'(disp_data), 32'h1234);

      // auto scan 3..5
      for (int i = 0; i < 40 && q_adr.size() < 4; i++) begin
         step(1'b0, 1'b1, 5'd1, 5'd3, 5'd5, 1'b0);
         if (obs_en) begin q_adr.push_back(obs_addr); q_cyc.push_back(cyc); end
      end
      chk("scan_count", 32'(q_adr.size()), 32'd4);
      if (q_adr.size() == 4) begin
         chk("scan_a0", 32'(q_adr[0]), 32'd3);
         chk("scan_a1", 32'(q_adr[1]), 32'd4);
         chk("scan_a2", 32'(q_adr[2]), 32'd5);
         chk("scan_a3", 32'(q_adr[3]), 32'd3);
         for (int i = 1; i < 4; i++) chk("scan_gap", 32'(q_cyc[i] - q_cyc[i-1]), 32'd7);
      end

      // hold raised while the read of address 4 is in flight
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         step(1'b0, 1'b1, 5'd1, 5'd3, 5'd5, 1'b0);
         found = obs_en && (obs_addr == 5'd4);
      end
      chk("hold_found4", 32'(found), 32'd1);
      n_str = 0;
      for (int i = 0; i < 22; i++) begin
         step(1'b0, 1'b1, 5'd1, 5'd3, 5'd5, 1'b1);
         if (obs_en) n_str++;
      end
      chk("hold_nostrobe", 32'(n_str), 32'd0);
      chk("hold_word", 32'(disp_addr), 32'd4);
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         step(1'b0, 1'b1, 5'd1, 5'd3, 5'd5, 1'b0);
         found = obs_en;
      end
      chk("release_strobe", 32'(found), 32'd1);
      chk("release_addr", 32'(obs_addr), 32'd5);

      // reset one cycle after an issue discards the read
      step(1'b1, 1'b1, 5'd1, 5'd3, 5'd5, 1'b0);
      step(1'b0, 1'b1, 5'd1, 5'd3, 5'd5, 1'b0);
      chk("rst_fresh_strobe", 32'(obs_en), 32'd1);
      step(1'b1, 1'b1, 5'd1, 5'd3, 5'd5, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 5'd1, 5'd3, 5'd5, 1'b0);
         chk("rst_novalid", 32'(disp_valid), 32'd0);
      end
      step(1'b0, 1'b1, 5'd1, 5'd3, 5'd5, 1'b0);
      chk("rst_recapture", 32'(disp_valid), 32'd1);

      // randomized traffic with memory writes, bound changes, holds and resets
      rand_wr = 1'b1;
      r_mode = 1'b1; r_sel = 5'd7; r_lo = 5'd3; r_hi = 5'd5;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) r_mode = ~r_mode;
         if ($urandom_range(0, 29) == 0) r_sel = AW'($urandom);
         if ($urandom_range(0, 59) == 0) begin
            r_lo = AW'($urandom);
            r_hi = ($urandom_range(0, 4) == 0) ? AW'($urandom) : AW'(r_lo + AW'($urandom_range(0, 6)));
         end
         step(($urandom_range(0, 299) == 0), r_mode, r_sel, r_lo, r_hi,
              ($urandom_range(0, 19) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_watch_unit.md
MEM_WATCH_UNIT -- requirements
Module: mem_watch_unit

Interface
REQ-001 Parameter DATA_W, default 16: width of memory word and display data.
REQ-002 Parameter ADDR_W, default 5: width of watched-memory address.
REQ-003 Parameter RD_LAT, default 1, legal 1..4: memory read latency in cycles.
REQ-004 Parameter DWELL, default 1024, legal >=1: cycles a displayed word is held before the next read.
REQ-005 Port list SHALL be exactly as follows; one clock, clk_in; reset rst, asynchronous, active-high.
REQ-006 clk_in  input  1  system clock.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 mode  input  1  0 = manual watch of sel_addr; 1 = auto-scan scan_lo..scan_hi.
REQ-009 sel_addr  input  ADDR_W  address watched in manual mode.
REQ-010 scan_lo / scan_hi  input  ADDR_W each  inclusive auto-scan bounds.
REQ-011 hold  input  1  freeze display, counters and address.
REQ-012 mem_rd_en  output  1  one-cycle read strobe to watched memory.
REQ-013 mem_addr  output  ADDR_W  read address, valid while mem_rd_en=1.
REQ-014 mem_rd_data  input  DATA_W  read data, valid RD_LAT cycles after the strobe.
REQ-015 disp_data  output  DATA_W  registered word shown on display.
REQ-016 disp_addr  output  ADDR_W  address that disp_data was read from.
REQ-017 disp_valid  output  1  high once the first word is captured after reset.

Function
REQ-018 FSM states: ISSUE, WAIT, SHOW; ISSUE is entered in the first cycle after rst deasserts.
REQ-019 ISSUE, cycle T: mem_rd_en=1, mem_addr=current address; next state WAIT.
REQ-020 WAIT: latency counter counts RD_LAT cycles; mem_rd_data is sampled at the end of cycle T+RD_LAT; next state SHOW.
REQ-021 disp_data, disp_addr and disp_valid=1 SHALL update at the start of cycle T+RD_LAT+1.
REQ-022 SHOW: dwell counter counts DWELL cycles, then returns to ISSUE.
REQ-023 Manual mode: the address issued is the sel_addr value sampled in the ISSUE cycle.
REQ-024 Manual mode with unchanged sel_addr re-reads the same address every RD_LAT+DWELL+1 cycles, so memory writes become visible.
REQ-025 Manual mode: a sel_addr change during SHOW aborts the dwell; ISSUE follows next cycle.
REQ-026 Auto mode: the address advances by one per ISSUE, wrapping from scan_hi to scan_lo.
REQ-027 Auto mode with scan_lo > scan_hi: scan_lo is treated as the sole address.
REQ-028 Auto mode with current address outside [scan_lo, scan_hi] (bounds changed): the next ISSUE uses scan_lo.
REQ-029 Auto mode: the address counter wraps modulo 2^ADDR_W; no out-of-range address is ever issued.
REQ-030 A mode or sel_addr change during WAIT SHALL NOT abort the read; the returned data is tagged with the issued address.
REQ-031 hold=1 in SHOW or ISSUE: state, counters and outputs freeze, and mem_rd_en is forced to 0.
REQ-032 hold=1 in WAIT: the outstanding read completes and is captured, then the FSM freezes in SHOW.
REQ-033 Releasing hold resumes counting from the frozen dwell value.
REQ-034 Switching from auto to manual: the next ISSUE uses sel_addr.
REQ-035 Switching from manual to auto: the next ISSUE uses scan_lo.

Reset
REQ-036 rst asynchronously clears disp_data, disp_addr, disp_valid, mem_rd_en, mem_addr and all counters to 0.
REQ-037 While rst is high the FSM is held in ISSUE with mem_rd_en forced to 0.
REQ-038 Reset asserted mid-WAIT discards the in-flight read; no capture follows reset release.

Structure
REQ-039 Package mem_watch_pkg SHALL hold the state enum, the RD_LAT and DWELL legal-range constants and the default parameter values.
REQ-040 One sub-module, rd_return_pipe: an RD_LAT-deep valid/address shift register that flags the capture cycle and carries the issued address.
REQ-041 Elaboration SHALL fail for an RD_LAT or DWELL value outside its legal range.

Verification (DATA_W=16, ADDR_W=5, RD_LAT=2, DWELL=4)
REQ-042 rst=1 held 3 cycles with mem_rd_data=16'hFFFF -> disp_data=0, disp_addr=0, disp_valid=0, mem_rd_en=0 throughout.
REQ-043 Manual mode, sel_addr=1, mem[1]=16'hA5A5 -> mem_rd_en pulses with mem_addr=1 in the first cycle after reset release; disp_data=A5A5, disp_addr=1, disp_valid=1 three cycles later.
REQ-044 Manual mode, mem[1] rewritten to 16'h1234 -> disp_data=1234 within 7 cycles plus one full refresh period.
REQ-045 Auto mode, scan_lo=3, scan_hi=5 -> mem_addr sequence 3,4,5,3 at 7-cycle spacing; disp_addr follows each entry 3 cycles after its strobe.
REQ-046 hold=1 asserted in WAIT for address 4 -> word 4 is captured; no strobe for 20 cycles; after release the next strobe is at address 5.
REQ-047 rst pulsed one cycle after ISSUE -> no capture occurs; disp_valid=0 until a fresh read completes.
